cg_iteration_sequencer: RTL and testbench
=========================================

CG_ITERATION_SEQUENCER -- requirements
Module: cg_iteration_sequencer

Interface
REQ-001 SHALL have parameter element_width, default 32, meaning scalar/result width.
REQ-002 SHALL have parameter no_of_units, default 8, meaning vector elements processed per beat.
REQ-003 SHALL have parameter max_iter, default 1024, meaning iteration limit before timeout (legal range 1..2^iter_width-1).
REQ-004 SHALL have parameter iter_width, default 16, meaning iteration counter width.
REQ-005 SHALL have parameter tolerance, default 32'h283424DC, meaning convergence threshold on rs_new.
REQ-006 SHALL have clk  in  1  system clock; one clock domain.
REQ-007 SHALL have reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have start  in  1  begin solve; sampled only in IDLE.
REQ-009 SHALL have abort  in  1  cancel solve from any non-IDLE state.
REQ-010 SHALL have total  in  32  vector length in elements; sampled on accepted start.
REQ-011 SHALL have vxv_read  out  1  one-cycle read strobe per beat to the dot-product unit.
REQ-012 SHALL have vxv_done  in  1  dot-product complete pulse.
REQ-013 SHALL have vxv_result  in  element_width  dot-product value, valid with vxv_done.
REQ-014 SHALL have mxv_start, div_start, upd_xr_start, upd_p_start  out  1 each  one-cycle stage start pulses.
REQ-015 SHALL have mxv_done, div_done, upd_x_done, upd_r_done, upd_p_done  in  1 each  stage completion pulses.
REQ-016 SHALL have div_sel  out  1  0 = alpha division, 1 = beta division.
REQ-017 SHALL have rs_old, rs_new  out  element_width each  registered residual norms.
REQ-018 SHALL have busy, converged, timeout, aborted  out  1 each  status.
REQ-019 SHALL have iter_count  out  iter_width  completed iterations.

Function
REQ-020 SHALL implement states IDLE, RSOLD, MXV, ALPHA, UPD_XR, RSNEW, CHECK, BETA, UPD_P.
REQ-021 SHALL compute beats = ceil(total/no_of_units) on accepted start; start with total==0 SHALL stay IDLE and set aborted for that solve.
REQ-022 In RSOLD and RSNEW it SHALL assert vxv_read for exactly beats cycles, one per clock starting the cycle after state entry, then wait for vxv_done.
REQ-023 vxv_done in RSOLD SHALL load rs_old and go to MXV; in RSNEW it SHALL load rs_new and go to CHECK.
REQ-024 MXV SHALL pulse mxv_start on entry and go to ALPHA on mxv_done.
REQ-025 ALPHA SHALL pulse div_start with div_sel=0 and go to UPD_XR on div_done; BETA SHALL do the same with div_sel=1 and go to UPD_P.
REQ-026 UPD_XR SHALL pulse upd_xr_start and latch upd_x_done and upd_r_done independently (any order, same cycle allowed), going to RSNEW the cycle both are latched.
REQ-027 CHECK (one cycle) SHALL increment iter_count; if rs_new <= tolerance (unsigned bit compare, valid for non-negative IEEE-754) it SHALL set converged and go IDLE; else if the incremented count equals max_iter it SHALL set timeout and go IDLE; else go BETA.
REQ-028 On upd_p_done it SHALL copy rs_new into rs_old, then go to MXV (rs_old is not recomputed).
REQ-029 Done pulses arriving in a state not waiting for them SHALL be ignored.
REQ-030 abort SHALL return to IDLE next clock, set aborted, and suppress further start pulses and vxv_read; abort in IDLE SHALL have no effect.
REQ-031 busy SHALL be 1 in every state except IDLE; accepted start SHALL clear converged, timeout, aborted and iter_count.
REQ-032 Start pulses and vxv_read SHALL be registered outputs; start is ignored while busy.

Reset
REQ-033 On reset SHALL enter IDLE asynchronously with every output, rs_old, rs_new, iter_count and beat counter at 0; reset mid-solve SHALL discard all progress.

Verification
REQ-034 total=16, no_of_units=8, ideal stage models, vxv_result 0x3F800000 then 0x00000000 -> 2 vxv_read in RSOLD, 2 in RSNEW, converged=1, iter_count=1, busy=0.
REQ-035 total=17 -> 3 vxv_read strobes per dot-product phase.
REQ-036 rs_new always 0x3F800000, max_iter=3 -> timeout=1, iter_count=3, converged=0, exactly 3 upd_p_start pulses minus final (2).
REQ-037 upd_r_done 5 cycles before upd_x_done, then both in same cycle on next iteration -> single RSNEW entry each time.
REQ-038 abort during UPD_XR -> IDLE next clock, aborted=1, no further start pulses; reset asserted mid-RSNEW -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/cg_iteration_sequencer.sv
// Control sequencer for a conjugate-gradient solver. It steps the datapath through the
// dot-product, matrix-vector, division and update stages until convergence, timeout or abort.
module cg_iteration_sequencer #(
  parameter int                       element_width = 32,
  parameter int                       no_of_units   = 8,
  parameter int                       max_iter      = 1024,
  parameter int                       iter_width    = 16,
  parameter logic [element_width-1:0] tolerance     = element_width'(32'h283424DC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              total,
  output logic                     vxv_read,
  input  logic                     vxv_done,
  input  logic [element_width-1:0] vxv_result,
  output logic                     mxv_start,
  output logic                     div_start,
  output logic                     upd_xr_start,
  output logic                     upd_p_start,
  input  logic                     mxv_done,
  input  logic                     div_done,
  input  logic                     upd_x_done,
  input  logic                     upd_r_done,
  input  logic                     upd_p_done,
  output logic                     div_sel,
  output logic [element_width-1:0] rs_old,
  output logic [element_width-1:0] rs_new,
  output logic                     busy,
  output logic                     converged,
  output logic                     timeout,
  output logic                     aborted,
  output logic [iter_width-1:0]    iter_count
);

  typedef enum logic [3:0] {
    IDLE, RSOLD, MXV, ALPHA, UPD_XR, RSNEW, CHECK, BETA, UPD_P
  } state_t;

  localparam logic [32:0]           UNITS    = 33'(no_of_units);
  localparam logic [iter_width-1:0] MAX_ITER = iter_width'(max_iter);

  state_t                   state_reg, state_next;
  logic [31:0]              beats_reg, beats_next;
  logic [31:0]              beat_cnt_reg, beat_cnt_next;
  logic                     x_seen_reg, x_seen_next;
  logic                     r_seen_reg, r_seen_next;
  logic [element_width-1:0] rs_old_reg, rs_old_next;
  logic [element_width-1:0] rs_new_reg, rs_new_next;
  logic [iter_width-1:0]    iter_reg, iter_next, iter_inc;
  logic                     converged_reg, converged_next;
  logic                     timeout_reg, timeout_next;
  logic                     aborted_reg, aborted_next;
  logic                     div_sel_reg, div_sel_next;
  logic                     vxv_read_reg, vxv_read_next;
  logic                     mxv_start_reg, mxv_start_next;
  logic                     div_start_reg, div_start_next;
  logic                     upd_xr_start_reg, upd_xr_start_next;
  logic                     upd_p_start_reg, upd_p_start_next;

  // Widened by one bit so a total near 2^32 cannot wrap while rounding up.
  logic [32:0] beats_sum;
  logic [31:0] beats_calc;
  assign beats_sum  = {1'b0, total} + (UNITS - 33'd1);
  assign beats_calc = 32'(beats_sum / UNITS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      beats_reg        <= '0;
      beat_cnt_reg     <= '0;
      x_seen_reg       <= 1'b0;
      r_seen_reg       <= 1'b0;
      rs_old_reg       <= '0;
      rs_new_reg       <= '0;
      iter_reg         <= '0;
      converged_reg    <= 1'b0;
      timeout_reg      <= 1'b0;
      aborted_reg      <= 1'b0;
      div_sel_reg      <= 1'b0;
      vxv_read_reg     <= 1'b0;
      mxv_start_reg    <= 1'b0;
      div_start_reg    <= 1'b0;
      upd_xr_start_reg <= 1'b0;
      upd_p_start_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      beats_reg        <= beats_next;
      beat_cnt_reg     <= beat_cnt_next;
      x_seen_reg       <= x_seen_next;
      r_seen_reg       <= r_seen_next;
      rs_old_reg       <= rs_old_next;
      rs_new_reg       <= rs_new_next;
      iter_reg         <= iter_next;
      converged_reg    <= converged_next;
      timeout_reg      <= timeout_next;
      aborted_reg      <= aborted_next;
      div_sel_reg      <= div_sel_next;
      vxv_read_reg     <= vxv_read_next;
      mxv_start_reg    <= mxv_start_next;
      div_start_reg    <= div_start_next;
      upd_xr_start_reg <= upd_xr_start_next;
      upd_p_start_reg  <= upd_p_start_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    beats_next        = beats_reg;
    beat_cnt_next     = beat_cnt_reg;
    x_seen_next       = x_seen_reg;
    r_seen_next       = r_seen_reg;
    rs_old_next       = rs_old_reg;
    rs_new_next       = rs_new_reg;
    iter_next         = iter_reg;
    converged_next    = converged_reg;
    timeout_next      = timeout_reg;
    aborted_next      = aborted_reg;
    div_sel_next      = div_sel_reg;
    vxv_read_next     = 1'b0;
    mxv_start_next    = 1'b0;
    div_start_next    = 1'b0;
    upd_xr_start_next = 1'b0;
    upd_p_start_next  = 1'b0;
    iter_inc          = iter_reg + 1'b1;

    if (abort && state_reg != IDLE) begin
      state_next   = IDLE;
      aborted_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            converged_next = 1'b0;
            timeout_next   = 1'b0;
            iter_next      = '0;
            if (total == '0) begin
              aborted_next = 1'b1;
            end else begin
              aborted_next = 1'b0;
              beats_next   = beats_calc;
              state_next   = RSOLD;
            end
          end
        end
        RSOLD: begin
          if (vxv_done && beat_cnt_reg == '0) begin
            rs_old_next = vxv_result;
            state_next  = MXV;
          end
        end
        MXV:   if (mxv_done) state_next = ALPHA;
        ALPHA: if (div_done) state_next = UPD_XR;
        UPD_XR: begin
          x_seen_next = x_seen_reg | upd_x_done;
          r_seen_next = r_seen_reg | upd_r_done;
          if (x_seen_next && r_seen_next) state_next = RSNEW;
        end
        RSNEW: begin
          if (vxv_done && beat_cnt_reg == '0) begin
            rs_new_next = vxv_result;
            state_next  = CHECK;
          end
        end
        CHECK: begin
          iter_next = iter_inc;
          if (rs_new_reg <= tolerance) begin
            converged_next = 1'b1;
            state_next     = IDLE;
          end else if (iter_inc == MAX_ITER) begin
            timeout_next = 1'b1;
            state_next   = IDLE;
          end else begin
            state_next = BETA;
          end
        end
        BETA:  if (div_done) state_next = UPD_P;
        UPD_P: begin
          if (upd_p_done) begin
            rs_old_next = rs_new_reg;
            state_next  = MXV;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Stage strobes are registered on the transition so they appear in the first cycle of the state.
    if (state_next != state_reg) begin
      case (state_next)
        RSOLD, RSNEW: beat_cnt_next = beats_next;
        MXV:          mxv_start_next = 1'b1;
        ALPHA: begin
          div_start_next = 1'b1;
          div_sel_next   = 1'b0;
        end
        BETA: begin
          div_start_next = 1'b1;
          div_sel_next   = 1'b1;
        end
        UPD_XR: begin
          upd_xr_start_next = 1'b1;
          x_seen_next       = 1'b0;
          r_seen_next       = 1'b0;
        end
        UPD_P:   upd_p_start_next = 1'b1;
        default: ;
      endcase
    end else if ((state_reg == RSOLD || state_reg == RSNEW) && beat_cnt_reg != '0) begin
      vxv_read_next = 1'b1;
      beat_cnt_next = beat_cnt_reg - 1'b1;
    end
  end

  assign vxv_read     = vxv_read_reg;
  assign mxv_start    = mxv_start_reg;
  assign div_start    = div_start_reg;
  assign upd_xr_start = upd_xr_start_reg;
  assign upd_p_start  = upd_p_start_reg;
  assign div_sel      = div_sel_reg;
  assign rs_old       = rs_old_reg;
  assign rs_new       = rs_new_reg;
  assign busy         = (state_reg != IDLE);
  assign converged    = converged_reg;
  assign timeout      = timeout_reg;
  assign aborted      = aborted_reg;
  assign iter_count   = iter_reg;

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Bench for cg_iteration_sequencer: ideal stage responders plus a protocol-level model of
// the solve sequence, checked every cycle, and literal end-of-solve expectations.
module tb_cg_iteration_sequencer;

  localparam logic [31:0] TOL  = 32'h283424DC;
  localparam int          MAXI = 3;
  localparam int LAT_VXV = 2, LAT_MXV = 3, LAT_DIV = 2, LAT_P = 2;

  // Protocol positions: S_* = next pulse expected, W_* = stage started, awaiting its done.
  localparam int S_IDLE = 0, S_DP_OLD = 1, W_DP_OLD = 2, S_MXV = 3, W_MXV = 4,
                 S_DIV_A = 5, W_DIV_A = 6, S_XR = 7, W_XR = 8, S_DP_NEW = 9,
                 W_DP_NEW = 10, S_DIV_B = 11, W_DIV_B = 12, S_P = 13, W_P = 14;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] total;
  logic        vxv_read, vxv_done;
  logic [31:0] vxv_result;
  logic        mxv_start, div_start, upd_xr_start, upd_p_start;
  logic        mxv_done, div_done, upd_x_done, upd_r_done, upd_p_done;
  logic        div_sel;
  logic [31:0] rs_old, rs_new;
  logic        busy, converged, timeout, aborted;
  logic [15:0] iter_count;

  cg_iteration_sequencer #(.max_iter(MAXI)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .total(total),
    .vxv_read(vxv_read), .vxv_done(vxv_done), .vxv_result(vxv_result),
    .mxv_start(mxv_start), .div_start(div_start), .upd_xr_start(upd_xr_start),
    .upd_p_start(upd_p_start), .mxv_done(mxv_done), .div_done(div_done),
    .upd_x_done(upd_x_done), .upd_r_done(upd_r_done), .upd_p_done(upd_p_done),
    .div_sel(div_sel), .rs_old(rs_old), .rs_new(rs_new), .busy(busy),
    .converged(converged), .timeout(timeout), .aborted(aborted), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Solve configuration written by the stimulus before each start.
  logic [31:0] cfg_total;
  int          cfg_beats;
  logic [31:0] cfg_rsold;
  logic [31:0] cfg_rsnew [0:7];
  int          lat_x_tab [0:7];
  int          lat_r_tab [0:7];

  // Model state, owned by the compare process.
  int          exp_st = S_IDLE;
  logic [31:0] m_rs_old = '0, m_rs_new = '0;
  int          m_iter = 0;
  logic        m_conv = 1'b0, m_tmo = 1'b0, m_abt = 1'b0;
  int          cnt_reads = 0, cnt_p = 0;
  int          rd_in_phase = 0, xr_idx = 0;
  int          t_vxv = 0, t_mxv = 0, t_div = 0, t_x = 0, t_r = 0, t_p = 0;
  logic        x_got = 1'b0, r_got = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process and ideal stage responders, evaluated at every falling edge.
  initial begin : compare_env
    vxv_done = 1'b0; mxv_done = 1'b0; div_done = 1'b0;
    upd_x_done = 1'b0; upd_r_done = 1'b0; upd_p_done = 1'b0; vxv_result = '0;
    forever begin
      @(negedge clk);
      vxv_done = 1'b0; mxv_done = 1'b0; div_done = 1'b0;
      upd_x_done = 1'b0; upd_r_done = 1'b0; upd_p_done = 1'b0;
      if (reset) begin
        exp_st = S_IDLE; m_rs_old = '0; m_rs_new = '0; m_iter = 0;
        m_conv = 1'b0; m_tmo = 1'b0; m_abt = 1'b0;
        t_vxv = 0; t_mxv = 0; t_div = 0; t_x = 0; t_r = 0; t_p = 0;
        continue;
      end
      chk("rs_old", 64'(rs_old), 64'(m_rs_old));
      chk("rs_new", 64'(rs_new), 64'(m_rs_new));

      if (start && exp_st == S_IDLE) begin
        m_conv = 1'b0; m_tmo = 1'b0; m_iter = 0;
        cnt_reads = 0; cnt_p = 0; rd_in_phase = 0; xr_idx = 0;
        if (cfg_total == 0) m_abt = 1'b1;
        else begin m_abt = 1'b0; exp_st = S_DP_OLD; end
      end
      if (abort && exp_st != S_IDLE) begin
        exp_st = S_IDLE; m_abt = 1'b1;
      end

      if (vxv_read || mxv_start || div_start || upd_xr_start || upd_p_start)
        chk("busy_with_pulse", 64'(busy), 64'd1);
      if (vxv_read) begin
        cnt_reads++;
        chk("seq_read", 64'(exp_st == S_DP_OLD || exp_st == S_DP_NEW), 64'd1);
        if (exp_st == S_DP_OLD || exp_st == S_DP_NEW) begin
          rd_in_phase++;
          if (rd_in_phase == cfg_beats) begin
            rd_in_phase = 0;
            t_vxv = LAT_VXV;
            exp_st = (exp_st == S_DP_OLD) ? W_DP_OLD : W_DP_NEW;
          end
        end
      end
      if (mxv_start) begin
        chk("seq_mxv", 64'(exp_st == S_MXV), 64'd1);
        exp_st = W_MXV; t_mxv = LAT_MXV;
      end
      if (div_start) begin
        chk("seq_div", 64'(exp_st == S_DIV_A || exp_st == S_DIV_B), 64'd1);
        chk("div_sel", 64'(div_sel), 64'(exp_st == S_DIV_B));
        exp_st = (exp_st == S_DIV_B) ? W_DIV_B : W_DIV_A; t_div = LAT_DIV;
      end
      if (upd_xr_start) begin
        chk("seq_upd_xr", 64'(exp_st == S_XR), 64'd1);
        exp_st = W_XR; x_got = 1'b0; r_got = 1'b0;
        t_x = lat_x_tab[xr_idx]; t_r = lat_r_tab[xr_idx];
        if (xr_idx < 7) xr_idx++;
      end
      if (upd_p_start) begin
        cnt_p++;
        chk("seq_upd_p", 64'(exp_st == S_P), 64'd1);
        exp_st = W_P; t_p = LAT_P;
      end

      if (t_vxv > 0 && --t_vxv == 0) begin
        vxv_done = 1'b1;
        vxv_result = 32'hDEADBEEF;
        if (exp_st == W_DP_OLD) begin
          vxv_result = cfg_rsold; m_rs_old = cfg_rsold; exp_st = S_MXV;
        end else if (exp_st == W_DP_NEW) begin
          vxv_result = cfg_rsnew[m_iter]; m_rs_new = cfg_rsnew[m_iter]; m_iter++;
          if (m_rs_new <= TOL) begin m_conv = 1'b1; exp_st = S_IDLE; end
          else if (m_iter == MAXI) begin m_tmo = 1'b1; exp_st = S_IDLE; end
          else exp_st = S_DIV_B;
        end
      end
      if (t_mxv > 0 && --t_mxv == 0) begin
        mxv_done = 1'b1;
        if (exp_st == W_MXV) exp_st = S_DIV_A;
      end
      if (t_div > 0 && --t_div == 0) begin
        div_done = 1'b1;
        if (exp_st == W_DIV_A) exp_st = S_XR;
        else if (exp_st == W_DIV_B) exp_st = S_P;
      end
      if (t_x > 0 && --t_x == 0) begin upd_x_done = 1'b1; x_got = 1'b1; end
      if (t_r > 0 && --t_r == 0) begin upd_r_done = 1'b1; r_got = 1'b1; end
      if (exp_st == W_XR && x_got && r_got) begin
        exp_st = S_DP_NEW; rd_in_phase = 0;
      end
      if (t_p > 0 && --t_p == 0) begin
        upd_p_done = 1'b1;
        if (exp_st == W_P) begin m_rs_old = m_rs_new; exp_st = S_MXV; end
      end
    end
  end

  task automatic set_cfg(input logic [31:0] tot, input int beats, input logic [31:0] rso,
                         input logic [31:0] rn0, input logic [31:0] rn1, input logic [31:0] rn2,
                         input int lx0, input int lr0, input int lxn, input int lrn);
    cfg_total = tot; cfg_beats = beats; cfg_rsold = rso;
    for (int i = 0; i < 8; i++) begin
      cfg_rsnew[i] = (i == 0) ? rn0 : (i == 1) ? rn1 : rn2;
      lat_x_tab[i] = (i == 0) ? lx0 : lxn;
      lat_r_tab[i] = (i == 0) ? lr0 : lrn;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    total = cfg_total; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_solve();
    bit ended;
    ended = 1'b0;
    pulse_start();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (!busy) begin ended = 1'b1; break; end
    end
    chk("solve_end_within_budget", 64'(ended), 64'd1);
  endtask

  task automatic check_result(input string tag, input logic conv, input logic tmo,
                              input logic abt, input int iters, input int reads, input int ps);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_converged"}, 64'(converged), 64'(conv));
    chk({tag, "_timeout"}, 64'(timeout), 64'(tmo));
    chk({tag, "_aborted"}, 64'(aborted), 64'(abt));
    chk({tag, "_iter_count"}, 64'(iter_count), 64'(iters));
    chk({tag, "_reads"}, 64'(cnt_reads), 64'(reads));
    chk({tag, "_upd_p_starts"}, 64'(cnt_p), 64'(ps));
    chk({tag, "_model_conv"}, 64'(converged), 64'(m_conv));
    chk({tag, "_model_iter"}, 64'(iter_count), 64'(m_iter));
    chk({tag, "_sequence_complete"}, 64'(exp_st), 64'(S_IDLE));
    $display("solve %s: converged=%0d timeout=%0d aborted=%0d iter=%0d reads=%0d upd_p=%0d",
             tag, converged, timeout, aborted, iter_count, cnt_reads, cnt_p);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rs_old"}, 64'(rs_old), 64'd0);
    chk({tag, "_rs_new"}, 64'(rs_new), 64'd0);
    chk({tag, "_iter_count"}, 64'(iter_count), 64'd0);
    chk({tag, "_pulses"}, 64'({vxv_read, mxv_start, div_start, upd_xr_start, upd_p_start}), 64'd0);
    chk({tag, "_status"}, 64'({converged, timeout, aborted, div_sel}), 64'd0);
  endtask

  initial begin : stimulus
    bit seen;
    int n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; total = '0;
    set_cfg(32'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 1, 1, 1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check_all_zero("reset");
    $display("reset: outputs idle");

    // total=16: two beats per dot product, converges on the first check.
    set_cfg(32'd16, 2, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000, 1, 1, 1, 1);
    run_solve();
    check_result("t16_conv", 1'b1, 1'b0, 1'b0, 1, 4, 0);

    // total=17 rounds up to three beats.
    set_cfg(32'd17, 3, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000, 1, 1, 1, 1);
    run_solve();
    check_result("t17_conv", 1'b1, 1'b0, 1'b0, 1, 6, 0);

    // Residual never drops: timeout after max_iter iterations, two direction updates.
    set_cfg(32'd16, 2, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1, 1, 1, 1);
    run_solve();
    check_result("timeout", 1'b0, 1'b1, 1'b0, 3, 8, 2);

    // r done five cycles before x, then both together on the second iteration.
    set_cfg(32'd8, 1, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h00000000, 6, 1, 3, 3);
    run_solve();
    check_result("xr_order", 1'b1, 1'b0, 1'b0, 2, 3, 1);

    // Tolerance boundary: one above does not converge, exactly equal does.
    set_cfg(32'd1, 1, 32'h3F800000, 32'h283424DD, 32'h283424DC, 32'h00000000, 1, 1, 1, 1);
    run_solve();
    check_result("tol_edge", 1'b1, 1'b0, 1'b0, 2, 3, 1);

    // Zero-length vector: stays idle and reports aborted.
    set_cfg(32'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 1, 1);
    pulse_start();
    @(negedge clk); #1;
    chk("zero_total_busy", 64'(busy), 64'd0);
    chk("zero_total_aborted", 64'(aborted), 64'd1);
    chk("zero_total_model_aborted", 64'(aborted), 64'(m_abt));
    $display("solve zero_total: busy=%0d aborted=%0d", busy, aborted);

    // Abort while waiting in UPD_XR; late done pulses must be ignored afterwards.
    set_cfg(32'd16, 2, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000, 20, 20, 20, 20);
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (upd_xr_start) begin seen = 1'b1; break; end
    end
    chk("abort_reached_upd_xr", 64'(seen), 64'd1);
    abort = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0;
    chk("abort_busy_next_clock", 64'(busy), 64'd0);
    chk("abort_aborted", 64'(aborted), 64'd1);
    repeat (30) @(negedge clk);
    #1;
    check_result("abort", 1'b0, 1'b0, 1'b1, 0, 2, 0);
    chk("abort_rs_old_kept", 64'(rs_old), 64'h3F800000);

    // Reset in the middle of RSNEW clears everything without waiting for a clock edge.
    set_cfg(32'd16, 2, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000, 1, 1, 1, 1);
    pulse_start();
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      @(negedge clk); #1;
      if (vxv_read) n++;
    end
    chk("rsnew_reached", 64'(n), 64'd3);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    $display("async reset mid-RSNEW: busy=%0d rs_old=%0h", busy, rs_old);
    @(negedge clk); #1;
    reset = 1'b0;

    // Solve again after the reset.
    set_cfg(32'd8, 1, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000, 1, 1, 1, 1);
    run_solve();
    check_result("after_reset", 1'b1, 1'b0, 1'b0, 1, 2, 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
